goertzel_ctrl: RTL and testbench
================================

GOERTZEL_CTRL -- requirements
Module: goertzel_ctrl

Interface
REQ-001 Parameters SHALL be: N_MAX, 32, samples per frame; WIDTH, 16, sample/result bit width; BIN_NUM, 4, bins read out per frame; TIMEOUT, 64, maximum cycles to wait for engine done.
REQ-002 i_sys_clk  in  1  single clock; all logic on its rising edge.
REQ-003 i_sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-004 i_start  in  1  frame start request.
REQ-005 i_abort  in  1  abort the current frame.
REQ-006 i_x_valid / o_x_ready / i_x  in / out / in  1 / 1 / WIDTH signed  sample stream handshake.
REQ-007 o_eng_clr  out  1  engine synchronous clear pulse.
REQ-008 o_eng_enable / o_eng_x  out / out  1 / WIDTH signed  engine sample strobe and sample.
REQ-009 i_eng_done  in  1  engine accumulation complete.
REQ-010 o_eng_rd / o_eng_bin  out / out  1 / clog2(BIN_NUM)  engine result read request and bin index.
REQ-011 i_eng_y_valid / i_eng_y_re / i_eng_y_im  in / in / in  1 / WIDTH / WIDTH  engine result return.
REQ-012 o_y_valid / i_y_ready  out / in  1 / 1  result output handshake.
REQ-013 o_y_re / o_y_im / o_y_bin  out / out / out  WIDTH / WIDTH / clog2(BIN_NUM)  registered result and bin tag.
REQ-014 o_busy / o_frame_done / o_err  out / out / out  1 / 1 / 1  busy when not IDLE; one-cycle frame-complete pulse; sticky timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, FEED, WAIT_DONE, READ, OUT.
REQ-016 IDLE: i_start=1 -> CLEAR; o_err SHALL clear on the same edge.
REQ-017 CLEAR: o_eng_clr=1 for exactly one cycle; sample counter and bin counter zeroed; -> FEED.
REQ-018 FEED: o_x_ready=1; each cycle with i_x_valid=1 SHALL assert o_eng_enable combinationally, with o_eng_x=i_x (zero latency) and the sample counter incremented.
REQ-019 FEED: on acceptance of sample N_MAX-1 -> WAIT_DONE; o_eng_enable SHALL never assert outside FEED, and o_eng_x SHALL be 0 when o_eng_enable=0.
REQ-020 WAIT_DONE: i_eng_done=1 -> READ; otherwise a wait counter increments; on reaching TIMEOUT: o_err<=1, o_eng_clr pulse, -> IDLE.
REQ-021 READ: o_eng_rd=1 for exactly one cycle with o_eng_bin=bin counter; the FSM then holds until i_eng_y_valid=1.
REQ-022 On i_eng_y_valid, o_y_re, o_y_im and o_y_bin SHALL be registered -> OUT; i_eng_y_valid outside READ is ignored.
REQ-023 OUT: o_y_valid=1 and output data stable until i_y_ready=1.
REQ-024 On the OUT handshake, if bin=BIN_NUM-1: o_frame_done=1 for one cycle -> IDLE; otherwise bin+1 -> READ.
REQ-025 i_start outside IDLE SHALL be ignored (not queued).
REQ-026 i_abort in any non-IDLE state: -> IDLE next edge; o_eng_clr pulse; o_y_valid drops; o_frame_done and o_err are not asserted.
REQ-027 i_abort has priority over every other transition in the same cycle, including the final FEED acceptance and the OUT handshake.
REQ-028 Counters SHALL wrap only by explicit reset; the sample counter is clog2(N_MAX)+1 bits wide; the wait counter saturates at TIMEOUT.

Reset
REQ-029 Asserting i_sys_rst_n low SHALL asynchronously force IDLE with all counters 0 and all outputs 0, including o_err, o_y_re, o_y_im and o_y_bin.
REQ-030 Reset mid-frame SHALL discard all progress; the first frame after reset requires a new i_start.

Verification
REQ-031 Normal frame: N_MAX=32, BIN_NUM=4, i_start, 32 valid samples back-to-back, engine done 2 cycles later with y=bin*16 -> exactly 32 o_eng_enable, 4 results tagged 0..3, one o_frame_done.
REQ-032 Backpressure: i_x_valid toggling 50% and i_y_ready low for 5 cycles per result -> enable count still 32, outputs held stable, no result lost or duplicated.
REQ-033 Timeout: i_eng_done never asserted -> o_err=1 exactly TIMEOUT cycles after WAIT_DONE entry, o_eng_clr pulses, FSM in IDLE; the next i_start clears o_err.
REQ-034 Abort: i_abort at sample 10 -> IDLE next cycle, o_eng_clr=1, no o_frame_done; a following frame completes normally.
REQ-035 Async reset during OUT with o_y_valid=1 -> all outputs 0 immediately, without a clock edge.
REQ-036 i_start pulsed during FEED and OUT -> ignored; exactly one frame is processed.

Source files
------------

// File: rtl/goertzel_ctrl.sv
// goertzel_ctrl: frame sequencer wrapped around a Goertzel accumulation engine.
// It clears the engine, streams N_MAX samples into it, waits (bounded) for the
// engine to finish, then reads BIN_NUM results out one at a time through a
// valid/ready output port.
//
// Ports
//   i_sys_clk, i_sys_rst_n          clock, async active-low reset
//   i_start, i_abort                frame start request / abort current frame
//   i_x_valid, o_x_ready, i_x       sample stream handshake (signed WIDTH)
//   o_eng_clr                       one-cycle engine clear pulse
//   o_eng_enable, o_eng_x           zero-latency sample strobe and sample to engine
//   i_eng_done                      engine accumulation complete
//   o_eng_rd, o_eng_bin             one-cycle result read request and bin index
//   i_eng_y_valid, i_eng_y_re/im    engine result return
//   o_y_valid, i_y_ready            result output handshake
//   o_y_re, o_y_im, o_y_bin         registered result and its bin tag
//   o_busy, o_frame_done, o_err     not-idle, frame-complete pulse, sticky timeout
module goertzel_ctrl #(
   parameter int unsigned N_MAX   = 32,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned BIN_NUM = 4,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned BW     = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_rst_n,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic                    i_x_valid,
   output logic                    o_x_ready,
   input  logic signed [WIDTH-1:0] i_x,
   output logic                    o_eng_clr,
   output logic                    o_eng_enable,
   output logic signed [WIDTH-1:0] o_eng_x,
   input  logic                    i_eng_done,
   output logic                    o_eng_rd,
   output logic [BW-1:0]           o_eng_bin,
   input  logic                    i_eng_y_valid,
   input  logic [WIDTH-1:0]        i_eng_y_re,
   input  logic [WIDTH-1:0]        i_eng_y_im,
   output logic                    o_y_valid,
   input  logic                    i_y_ready,
   output logic [WIDTH-1:0]        o_y_re,
   output logic [WIDTH-1:0]        o_y_im,
   output logic [BW-1:0]           o_y_bin,
   output logic                    o_busy,
   output logic                    o_frame_done,
   output logic                    o_err
);

   localparam int unsigned SCW = $clog2(N_MAX) + 1;
   localparam int unsigned WCW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_WAIT_DONE,
      S_READ,
      S_OUT
   } state_t;

   state_t          state;
   logic [SCW-1:0]  sample_cnt;
   logic [WCW-1:0]  wait_cnt;
   logic [BW-1:0]   bin_cnt;
   logic            in_feed_c;
   logic            accept_c;

   // Abort wins over sample acceptance, so a sample offered in the abort
   // cycle never reaches the engine.
   assign in_feed_c    = (state == S_FEED) && !i_abort;
   assign accept_c     = in_feed_c && i_x_valid;
   assign o_x_ready    = in_feed_c;
   assign o_eng_enable = accept_c;
   assign o_eng_x      = accept_c ? i_x : '0;
   assign o_busy       = (state != S_IDLE);

   // Frame sequencer: state, counters and registered outputs.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state        <= S_IDLE;
         sample_cnt   <= '0;
         wait_cnt     <= '0;
         bin_cnt      <= '0;
         o_eng_clr    <= 1'b0;
         o_eng_rd     <= 1'b0;
         o_eng_bin    <= '0;
         o_y_valid    <= 1'b0;
         o_y_re       <= '0;
         o_y_im       <= '0;
         o_y_bin      <= '0;
         o_frame_done <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         // Pulse outputs default low every cycle.
         o_eng_clr    <= 1'b0;
         o_eng_rd     <= 1'b0;
         o_frame_done <= 1'b0;

         if (i_abort && (state != S_IDLE)) begin
            state     <= S_IDLE;
            o_eng_clr <= 1'b1;
            o_y_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_start) begin
                     state     <= S_CLEAR;
                     o_err     <= 1'b0;
                     // Registered so the clear is high throughout CLEAR.
                     o_eng_clr <= 1'b1;
                  end
               end

               S_CLEAR: begin
                  sample_cnt <= '0;
                  bin_cnt    <= '0;
                  wait_cnt   <= '0;
                  state      <= S_FEED;
               end

               S_FEED: begin
                  if (i_x_valid) begin
                     sample_cnt <= sample_cnt + SCW'(1);
                     if (sample_cnt == SCW'(N_MAX - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT_DONE;
                     end
                  end
               end

               S_WAIT_DONE: begin
                  if (i_eng_done) begin
                     o_eng_rd  <= 1'b1;
                     o_eng_bin <= bin_cnt;
                     state     <= S_READ;
                  end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                     // TIMEOUT edges after entry: flag, clear engine, give up.
                     wait_cnt  <= WCW'(TIMEOUT);
                     o_err     <= 1'b1;
                     o_eng_clr <= 1'b1;
                     state     <= S_IDLE;
                  end else if (wait_cnt != WCW'(TIMEOUT)) begin
                     wait_cnt <= wait_cnt + WCW'(1);
                  end
               end

               S_READ: begin
                  if (i_eng_y_valid) begin
                     o_y_re    <= i_eng_y_re;
                     o_y_im    <= i_eng_y_im;
                     o_y_bin   <= bin_cnt;
                     o_y_valid <= 1'b1;
                     state     <= S_OUT;
                  end
               end

               S_OUT: begin
                  if (i_y_ready) begin
                     o_y_valid <= 1'b0;
                     if (bin_cnt == BW'(BIN_NUM - 1)) begin
                        o_frame_done <= 1'b1;
                        state        <= S_IDLE;
                     end else begin
                        bin_cnt   <= bin_cnt + BW'(1);
                        o_eng_rd  <= 1'b1;
                        o_eng_bin <= bin_cnt + BW'(1);
                        state     <= S_READ;
                     end
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Directed bench for goertzel_ctrl with a small behavioural engine model.
module tb_goertzel_ctrl;

   localparam int TIMEOUT = 64;

   logic               clk;
   logic               i_sys_rst_n;
   logic               i_start;
   logic               i_abort;
   logic               i_x_valid;
   logic               o_x_ready;
   logic signed [15:0] i_x;
   logic               o_eng_clr;
   logic               o_eng_enable;
   logic signed [15:0] o_eng_x;
   logic               i_eng_done;
   logic               o_eng_rd;
   logic [1:0]         o_eng_bin;
   logic               i_eng_y_valid;
   logic [15:0]        i_eng_y_re;
   logic [15:0]        i_eng_y_im;
   logic               o_y_valid;
   logic               i_y_ready;
   logic [15:0]        o_y_re;
   logic [15:0]        o_y_im;
   logic [1:0]         o_y_bin;
   logic               o_busy;
   logic               o_frame_done;
   logic               o_err;

   goertzel_ctrl #(.N_MAX(32), .WIDTH(16), .BIN_NUM(4), .TIMEOUT(TIMEOUT)) dut (
      .i_sys_clk    (clk),
      .i_sys_rst_n  (i_sys_rst_n),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_x_valid    (i_x_valid),
      .o_x_ready    (o_x_ready),
      .i_x          (i_x),
      .o_eng_clr    (o_eng_clr),
      .o_eng_enable (o_eng_enable),
      .o_eng_x      (o_eng_x),
      .i_eng_done   (i_eng_done),
      .o_eng_rd     (o_eng_rd),
      .o_eng_bin    (o_eng_bin),
      .i_eng_y_valid(i_eng_y_valid),
      .i_eng_y_re   (i_eng_y_re),
      .i_eng_y_im   (i_eng_y_im),
      .o_y_valid    (o_y_valid),
      .i_y_ready    (i_y_ready),
      .o_y_re       (o_y_re),
      .o_y_im       (o_y_im),
      .o_y_bin      (o_y_bin),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_err        (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Event counters and result log.
   int en_cnt  = 0;
   int fd_cnt  = 0;
   typedef struct {
      logic [1:0]  bin;
      logic [15:0] re;
      logic [15:0] im;
   } res_t;
   res_t rq[$];

   always @(posedge clk) begin
      if (o_eng_enable) en_cnt++;
      if (o_frame_done) fd_cnt++;
      if (o_y_valid && i_y_ready) rq.push_back('{o_y_bin, o_y_re, o_y_im});
   end

   // Engine model: done 2 cycles after the 32nd sample, result one cycle
   // after each read with re = bin*16, im = 0x100 + bin*16.
   logic       done_en;
   int         eng_cnt;
   int         dly;
   always @(posedge clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         eng_cnt       <= 0;
         dly           <= 0;
         i_eng_done    <= 1'b0;
         i_eng_y_valid <= 1'b0;
         i_eng_y_re    <= '0;
         i_eng_y_im    <= '0;
      end else begin
         i_eng_y_valid <= 1'b0;
         if (o_eng_clr) begin
            eng_cnt    <= 0;
            dly        <= 0;
            i_eng_done <= 1'b0;
         end else begin
            if (o_eng_enable) eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 32 && done_en) begin
               if (dly < 2) dly <= dly + 1;
               i_eng_done <= (dly >= 1);
            end
         end
         if (o_eng_rd) begin
            i_eng_y_valid <= 1'b1;
            i_eng_y_re    <= {10'd0, o_eng_bin, 4'd0};
            i_eng_y_im    <= 16'h0100 | {10'd0, o_eng_bin, 4'd0};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
   endtask

   task automatic feed_burst(input int n);
      for (int k = 0; k < n; k++) begin
         i_x_valid = 1'b1;
         i_x       = 16'(k + 1);
         tick();
      end
      i_x_valid = 1'b0;
   endtask

   task automatic wait_frame(input int fd0);
      i_y_ready = 1'b1;
      for (int c = 0; c < 300 && fd_cnt == fd0; c++) tick();
   endtask

   task automatic check_results(input string tag);
      chk({tag, "_count"}, 32'(rq.size()), 4);
      for (int b = 0; b < 4; b++) begin
         if (b < rq.size()) begin
            chk({tag, "_bin"}, 32'(rq[b].bin), 32'(b));
            chk({tag, "_re"},  32'(rq[b].re),  32'(b * 16));
            chk({tag, "_im"},  32'(rq[b].im),  32'(256 + b * 16));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   int  fd0;
   int  e0;
   bit  pulsed;

   initial begin
      i_sys_rst_n = 1'b0;
      i_start     = 1'b0;
      i_abort     = 1'b0;
      i_x_valid   = 1'b0;
      i_x         = '0;
      i_y_ready   = 1'b0;
      done_en     = 1'b1;
      #1;
      // Reset state
      chk("rst_busy",    32'(o_busy), 0);
      chk("rst_err",     32'(o_err), 0);
      chk("rst_yvalid",  32'(o_y_valid), 0);
      chk("rst_clr",     32'(o_eng_clr), 0);
      chk("rst_xready",  32'(o_x_ready), 0);
      tick();
      tick();
      i_sys_rst_n = 1'b1;
      tick();

      // Normal frame, with start pulses in FEED and OUT ignored
      fd0 = fd_cnt; e0 = en_cnt; rq.delete();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("n_busy", 32'(o_busy), 1);
      chk("n_clr",  32'(o_eng_clr), 1);
      tick();
      chk("n_clr_one", 32'(o_eng_clr), 0);
      chk("n_xready",  32'(o_x_ready), 1);
      i_x = 16'sd1234;
      #1;
      chk("n_engx_idle", 32'(o_eng_x), 0);
      chk("n_en_idle",   32'(o_eng_enable), 0);
      for (int k = 0; k < 32; k++) begin
         i_x_valid = 1'b1;
         i_x       = 16'(k + 1);
         i_start   = (k == 5);
         if (k == 0) begin
            #1;
            chk("n_en_comb",   32'(o_eng_enable), 1);
            chk("n_engx_comb", 32'(o_eng_x), 1);
         end
         tick();
      end
      i_x_valid = 1'b0;
      i_start   = 1'b0;
      i_y_ready = 1'b1;
      pulsed    = 1'b0;
      for (int c = 0; c < 300 && fd_cnt == fd0; c++) begin
         if (o_y_valid && !pulsed) begin
            i_start = 1'b1;
            pulsed  = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         tick();
      end
      i_start = 1'b0;
      tick(); tick(); tick();
      chk("n_enables", 32'(en_cnt - e0), 32);
      chk("n_fdone",   32'(fd_cnt - fd0), 1);
      chk("n_idle",    32'(o_busy), 0);
      check_results("n");

      // Backpressure: 50% valid, 5 cycles of not-ready per result
      fd0 = fd_cnt; e0 = en_cnt; rq.delete();
      i_y_ready = 1'b0;
      start_frame();
      for (int c = 0; c < 200 && (en_cnt - e0) < 32; c++) begin
         i_x_valid = (c % 2 == 1);
         i_x       = 16'(c);
         tick();
      end
      i_x_valid = 1'b0;
      tick(); tick();
      chk("bp_enables", 32'(en_cnt - e0), 32);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 50 && !o_y_valid; c++) tick();
         repeat (5) tick();
         chk("bp_hold_valid", 32'(o_y_valid), 1);
         chk("bp_hold_re",    32'(o_y_re), 32'(r * 16));
         chk("bp_hold_bin",   32'(o_y_bin), 32'(r));
         i_y_ready = 1'b1;
         tick();
         i_y_ready = 1'b0;
      end
      tick(); tick();
      chk("bp_fdone", 32'(fd_cnt - fd0), 1);
      check_results("bp");

      // Timeout: engine never reports done
      done_en = 1'b0;
      start_frame();
      feed_burst(32);
      repeat (TIMEOUT - 1) tick();
      chk("to_err_early", 32'(o_err), 0);
      chk("to_busy_wait", 32'(o_busy), 1);
      tick();
      chk("to_err",  32'(o_err), 1);
      chk("to_clr",  32'(o_eng_clr), 1);
      chk("to_idle", 32'(o_busy), 0);
      tick();
      chk("to_sticky", 32'(o_err), 1);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("to_err_clr", 32'(o_err), 0);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      done_en = 1'b1;

      // Abort at sample 10, then a normal frame
      fd0 = fd_cnt; e0 = en_cnt;
      start_frame();
      feed_burst(10);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("ab_idle",    32'(o_busy), 0);
      chk("ab_clr",     32'(o_eng_clr), 1);
      chk("ab_enables", 32'(en_cnt - e0), 10);
      tick(); tick(); tick();
      chk("ab_no_fdone", 32'(fd_cnt - fd0), 0);
      chk("ab_no_err",   32'(o_err), 0);
      rq.delete();
      start_frame();
      feed_burst(32);
      wait_frame(fd0);
      tick();
      chk("ab_next_fdone", 32'(fd_cnt - fd0), 1);
      check_results("ab");

      // Asynchronous reset while presenting bin 2
      i_y_ready = 1'b0;
      start_frame();
      feed_burst(32);
      i_y_ready = 1'b1;
      for (int c = 0; c < 300 && !(o_y_valid && o_y_bin == 2'd2); c++) tick();
      i_y_ready = 1'b0;
      chk("ar_pre_valid", 32'(o_y_valid), 1);
      chk("ar_pre_re",    32'(o_y_re), 32);
      #2;
      i_sys_rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(o_y_valid), 0);
      chk("ar_re",    32'(o_y_re), 0);
      chk("ar_im",    32'(o_y_im), 0);
      chk("ar_bin",   32'(o_y_bin), 0);
      chk("ar_busy",  32'(o_busy), 0);
      chk("ar_rd",    32'(o_eng_rd), 0);
      tick();
      i_sys_rst_n = 1'b1;
      tick(); tick(); tick();
      chk("ar_no_restart", 32'(o_busy), 0);
      fd0 = fd_cnt; rq.delete();
      start_frame();
      feed_burst(32);
      wait_frame(fd0);
      tick();
      chk("ar_next_fdone", 32'(fd_cnt - fd0), 1);
      chk("ar_next_count", 32'(rq.size()), 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
